// File: rtl/sdrc_bank_arb_pkg.sv
// Shared command encodings, ID/length widths and arbiter state for the SDRAM bank arbiter.
// Column commands (RD/WR) carry bit 1 set so the class test is a single bit.
package sdrc_bank_arb_pkg;

  localparam int SDR_REQ_ID_W = 4;
  localparam int REQ_BW       = 12;
  localparam int NBANK        = 4;
  localparam int ADDR_W       = 13;

  typedef enum logic [1:0] {
    OP_PRE = 2'd0,
    OP_ACT = 2'd1,
    OP_RD  = 2'd2,
    OP_WR  = 2'd3
  } op_t;

  typedef enum logic {
    ST_OPEN = 1'b0,
    ST_LOCK = 1'b1
  } arb_state_t;

  function automatic logic is_col(input logic [1:0] cmd);
    return (cmd == OP_RD) || (cmd == OP_WR);
  endfunction

endpackage

// File: rtl/sdrc_rr_pick.sv
// Round-robin picker: first set request scanning ptr, ptr+1, ... mod 4.
// Purely combinational; idx is only meaningful when found=1.
module sdrc_rr_pick (
  input  logic [3:0] req,
  input  logic [1:0] ptr,
  output logic       found,
  output logic [1:0] idx
);
  import sdrc_bank_arb_pkg::*;

  // Scan from the farthest offset down so the nearest hit to ptr wins.
  always_comb begin
    found = 1'b0;
    idx   = ptr;
    for (int k = NBANK - 1; k >= 0; k--) begin
      if (req[2'(ptr + 2'(k))]) begin
        found = 1'b1;
        idx   = 2'(ptr + 2'(k));
      end
    end
  end

endmodule

// File: rtl/sdrc_bank_arb.sv
// Bank command arbiter: column-over-row priority with age-based row escalation,
// round-robin within a class, and a grant lock held until accept or withdrawal.
module sdrc_bank_arb #(
  parameter int SDR_REQ_ID_W = sdrc_bank_arb_pkg::SDR_REQ_ID_W,
  parameter int REQ_BW       = sdrc_bank_arb_pkg::REQ_BW,
  parameter int MAX_WAIT     = 8
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic [3:0]                b2a_req,
  input  logic [7:0]                b2a_cmd,
  input  logic [51:0]               b2a_addr,
  input  logic [4*SDR_REQ_ID_W-1:0] b2a_id,
  input  logic [4*REQ_BW-1:0]       b2a_len,
  input  logic [3:0]                b2a_start,
  input  logic [3:0]                b2a_last,
  input  logic [3:0]                b2a_wrap,
  output logic [3:0]                a2b_ack,
  output logic                      a2x_req,
  output logic [1:0]                a2x_cmd,
  output logic [1:0]                a2x_ba,
  output logic [12:0]               a2x_addr,
  output logic [SDR_REQ_ID_W-1:0]   a2x_id,
  output logic [REQ_BW-1:0]         a2x_len,
  output logic                      a2x_start,
  output logic                      a2x_last,
  output logic                      a2x_wrap,
  input  logic                      x2a_ack
);
  import sdrc_bank_arb_pkg::*;

  localparam logic [3:0] AGE_MAX = 4'(MAX_WAIT);

  arb_state_t state;
  logic       locked;
  logic [1:0] lock_bank;
  logic [1:0] rr_ptr;
  logic [3:0] age;

  logic [3:0] col_req, row_req;
  logic       col_found, row_found;
  logic [1:0] col_idx, row_idx;
  logic [1:0] open_bank, sel_bank;
  logic       sel_req, accept;

  assign locked = (state == ST_LOCK);

  always_comb begin
    col_req = '0;
    row_req = '0;
    for (int i = 0; i < NBANK; i++) begin
      col_req[i] = b2a_req[i] &  is_col(b2a_cmd[2*i +: 2]);
      row_req[i] = b2a_req[i] & ~is_col(b2a_cmd[2*i +: 2]);
    end
  end

  sdrc_rr_pick u_pick_col (.req(col_req), .ptr(rr_ptr), .found(col_found), .idx(col_idx));
  sdrc_rr_pick u_pick_row (.req(row_req), .ptr(rr_ptr), .found(row_found), .idx(row_idx));

  // Reset gates the request so outputs are quiet while reset_n is low.
  assign open_bank = (row_found && (age == AGE_MAX || !col_found)) ? row_idx : col_idx;
  assign sel_bank  = locked ? lock_bank : open_bank;
  assign sel_req   = reset_n & (locked ? b2a_req[lock_bank] : |b2a_req);
  assign accept    = sel_req & x2a_ack;

  always_comb begin
    a2x_req   = sel_req;
    a2b_ack   = '0;
    a2x_cmd   = '0;
    a2x_ba    = '0;
    a2x_addr  = '0;
    a2x_id    = '0;
    a2x_len   = '0;
    a2x_start = 1'b0;
    a2x_last  = 1'b0;
    a2x_wrap  = 1'b0;
    if (sel_req) begin
      a2b_ack   = accept ? (4'b0001 << sel_bank) : 4'b0000;
      a2x_cmd   = b2a_cmd[sel_bank*2 +: 2];
      a2x_ba    = sel_bank;
      a2x_addr  = b2a_addr[sel_bank*13 +: 13];
      a2x_id    = b2a_id[sel_bank*SDR_REQ_ID_W +: SDR_REQ_ID_W];
      a2x_len   = b2a_len[sel_bank*REQ_BW +: REQ_BW];
      a2x_start = b2a_start[sel_bank];
      a2x_last  = b2a_last[sel_bank];
      a2x_wrap  = b2a_wrap[sel_bank];
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= ST_OPEN;
      lock_bank <= '0;
      rr_ptr    <= '0;
      age       <= '0;
    end else begin
      case (state)
        ST_OPEN: if (sel_req && !x2a_ack) begin
          state     <= ST_LOCK;
          lock_bank <= sel_bank;
        end
        ST_LOCK: if (x2a_ack || !b2a_req[lock_bank]) state <= ST_OPEN;
        default: state <= ST_OPEN;
      endcase
      if (accept) rr_ptr <= sel_bank + 2'd1;
      // Age tracks how long pending row work has been passed over.
      if (!(|row_req) || (accept && !is_col(a2x_cmd))) age <= '0;
      else if (age != AGE_MAX) age <= age + 4'd1;
    end
  end

endmodule
